// File: rtl/gcore_pkg.sv
// Shared GCore fetch definitions: datapath widths, reset PC, fetch FSM encoding
// and the queued opcode entry layout.
package gcore_pkg;

  localparam int GC_ADDR_W = 8;
  localparam int GC_DATA_W = 8;
  localparam int GC_Q_DEPTH = 2;
  localparam logic [GC_ADDR_W-1:0] GC_RESET_PC = 8'h00;
  localparam int GC_ENTRY_W = GC_ADDR_W + GC_DATA_W;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [GC_ADDR_W-1:0] addr;
    logic [GC_DATA_W-1:0] data;
  } op_entry_t;

endpackage

// File: rtl/op_fetch_q.sv
// Small synchronous FIFO holding fetched {addr, data} entries for the decoder.
// The caller guarantees no push when full and no pop when empty.
module op_fetch_q #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; flush discards contents in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/op_fetch.sv
// Opcode fetch unit: walks the PC over opram, absorbs the 1-cycle read latency and
// hands {addr, opcode} to decode. Optional stall counter: OP_FETCH_STALLCNT_EN.
module op_fetch
  import gcore_pkg::*;
#(
  parameter int                ADDR_W   = GC_ADDR_W,
  parameter int                DATA_W   = GC_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = GC_RESET_PC,
  parameter int                Q_DEPTH  = GC_Q_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] ram_ad,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              halt,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_data,
  output logic [ADDR_W-1:0] op_addr
`ifdef OP_FETCH_STALLCNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] iss_addr_r;
  logic              inflight_r;
  logic              jmp_take_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              q_valid_s;
  logic [CNT_W-1:0]  q_count_s;
  logic [CNT_W:0]    occ_s;
  logic [CNT_W:0]    limit_s;
  logic [ENT_W-1:0]  q_rdata_s;

  assign jmp_take_s = jmp_valid && (state_r != S_BOOT);
  assign q_valid_s  = (q_count_s != {CNT_W{1'b0}});
  assign pop_s      = q_valid_s && op_ready;
  // A returning read is discarded when a redirect lands in the same cycle
  assign push_s     = inflight_r && !jmp_take_s;

  // Credit check: a slot freed by this cycle's pop may be re-issued immediately
  always_comb begin
    occ_s   = {1'b0, q_count_s} + {{CNT_W{1'b0}}, inflight_r};
    limit_s = (CNT_W + 1)'(Q_DEPTH) + {{CNT_W{1'b0}}, pop_s};
    issue_s = 1'b0;
    if ((state_r == S_RUN) && !halt && !jmp_take_s && (occ_s < limit_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch FSM, program counter and in-flight read tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_BOOT;
      pc_r       <= RESET_PC;
      iss_addr_r <= RESET_PC;
      inflight_r <= 1'b0;
    end else begin
      case (state_r)
        S_BOOT:  state_r <= S_RUN;
        S_RUN:   state_r <= halt ? S_HALT : S_RUN;
        S_HALT:  state_r <= halt ? S_HALT : S_RUN;
        default: state_r <= S_BOOT;
      endcase
      if (jmp_take_s) begin
        pc_r <= jmp_addr;
      end else if (issue_s) begin
        pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        pc_r <= pc_r;
      end
      if (issue_s) begin
        iss_addr_r <= pc_r;
      end else begin
        iss_addr_r <= iss_addr_r;
      end
      inflight_r <= issue_s;
    end
  end

  op_fetch_q #(
    .DEPTH (Q_DEPTH),
    .W     (ENT_W)
  ) u_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (jmp_take_s),
    .wdata   ({iss_addr_r, ram_dout}),
    .rdata   (q_rdata_s),
    .count   (q_count_s)
  );

  assign ram_ad    = pc_r;
  assign ram_ce    = issue_s;
  assign ram_oce   = 1'b1;
  assign ram_wre   = 1'b0;
  assign ram_reset = 1'b0;
  assign op_valid  = q_valid_s;
  assign {op_addr, op_data} = q_rdata_s;

`ifdef OP_FETCH_STALLCNT_EN
  logic [15:0] stall_r;

  // Saturating count of cycles the decoder holds off a valid opcode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= 16'h0000;
    end else if (q_valid_s && !op_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'h0001;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_op_fetch.sv
// Directed bench for op_fetch: behavioural opram with 1-cycle latency, stimulus driven
// and outputs sampled just after each falling edge; N<k> is the k-th falling edge after release.
module tb_op_fetch;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ram_ad;
  logic       ram_ce, ram_oce, ram_wre, ram_reset;
  logic [7:0] ram_dout = 8'h00;
  logic       halt = 1'b0;
  logic       jmp_valid = 1'b0;
  logic [7:0] jmp_addr = 8'h00;
  logic       op_valid;
  logic       op_ready = 1'b1;
  logic [7:0] op_data, op_addr;
`ifdef OP_FETCH_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] mem [256];
  int pass_cnt = 0;
  int total_cnt = 0;

  op_fetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ram_ad    (ram_ad),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_reset (ram_reset),
    .ram_dout  (ram_dout),
    .halt      (halt),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_data   (op_data),
    .op_addr   (op_addr)
`ifdef OP_FETCH_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // opram model: registered read, only when clock-enabled
  always @(posedge clk) begin
    if (ram_ce) ram_dout <= mem[ram_ad];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input string tag, input logic [7:0] a);
    chk({tag, "_valid"}, {31'd0, op_valid}, 32'd1);
    chk({tag, "_addr"}, {24'd0, op_addr}, {24'd0, a});
    chk({tag, "_data"}, {24'd0, op_data}, {24'd0, mem[a]});
  endtask

  task automatic chk_ce(input string tag, input logic ce, input logic [7:0] ad);
    chk({tag, "_ce"}, {31'd0, ram_ce}, {31'd0, ce});
    if (ce) chk({tag, "_ad"}, {24'd0, ram_ad}, {24'd0, ad});
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h46; mem[1] = 8'h20; mem[2] = 8'h41; mem[3] = 8'h21; mem[4] = 8'h42;

    // Reset state
    repeat (3) nxt();
    #1;
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ad", {24'd0, ram_ad}, 32'h00);
    chk("rst_data", {24'd0, op_data}, 32'h00);
    chk("rst_addr", {24'd0, op_addr}, 32'h00);
    chk("const_pins", {29'd0, ram_oce, ram_wre, ram_reset}, 32'b100);

    // Test 1: fill latency and streaming (N0 = release)
    reset_n = 1'b1; #1;
    chk("boot_ce", {31'd0, ram_ce}, 32'd0);
    nxt(); #1; chk_ce("n1", 1'b1, 8'h00); chk("n1_valid", {31'd0, op_valid}, 32'd0);
    nxt(); #1; chk_ce("n2", 1'b1, 8'h01); chk("n2_valid", {31'd0, op_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      nxt(); #1;
      chk_op("stream", 8'(k));
      chk_ce("stream", 1'b1, 8'(k + 2));
    end

    // Test 2: decoder backpressure for 10 cycles (N8..N17)
    nxt(); op_ready = 1'b0; #1;
    chk_op("bp_first", 8'h05); chk_ce("bp_first", 1'b0, 8'h00);
    for (int k = 0; k < 9; k++) begin
      nxt(); #1;
      chk_op("bp_hold", 8'h05); chk_ce("bp_hold", 1'b0, 8'h00);
    end
    nxt(); op_ready = 1'b1; #1;          // N18
    chk_op("bp_rel", 8'h05); chk_ce("bp_rel", 1'b1, 8'h07);
`ifdef OP_FETCH_STALLCNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd10);
`endif
    for (int k = 6; k < 10; k++) begin  // N19..N22 show 6..9
      nxt();
      if (k == 9) begin
        // Test 3: redirect with one queued op and one read in flight
        op_ready = 1'b0; jmp_valid = 1'b1; jmp_addr = 8'h10;
      end
      #1;
      chk_op("post_bp", 8'(k));
    end
    chk_ce("jmp_cycle", 1'b0, 8'h00);
    nxt(); jmp_valid = 1'b0; op_ready = 1'b1; #1;   // N23
    chk("jmp_flush1", {31'd0, op_valid}, 32'd0); chk_ce("jmp_n1", 1'b1, 8'h10);
    nxt(); #1;
    chk("jmp_flush2", {31'd0, op_valid}, 32'd0); chk_ce("jmp_n2", 1'b1, 8'h11);
    nxt(); #1; chk_op("jmp_op0", 8'h10);
    // Test 4: wrap-around redirect, coincident with a pop (N26)
    nxt(); jmp_valid = 1'b1; jmp_addr = 8'hFE; #1;
    chk_op("jmp_op1", 8'h11); chk_ce("wrap_jmp", 1'b0, 8'h00);
    nxt(); jmp_valid = 1'b0; #1;
    chk("wrap_flush", {31'd0, op_valid}, 32'd0); chk_ce("wrap_n1", 1'b1, 8'hFE);
    nxt(); #1; chk_ce("wrap_n2", 1'b1, 8'hFF);
    nxt(); #1; chk_op("wrap_fe", 8'hFE); chk_ce("wrap_n3", 1'b1, 8'h00);
    nxt(); #1; chk_op("wrap_ff", 8'hFF);
    nxt(); #1; chk_op("wrap_00", 8'h00);
    nxt(); #1; chk_op("wrap_01", 8'h01);   // N32

    // Test 5: halt for 5 cycles (N33..N37)
    nxt(); halt = 1'b1; #1;
    chk_op("halt_q", 8'h02); chk_ce("halt0", 1'b0, 8'h00);
    nxt(); #1; chk_op("halt_last", 8'h03); chk_ce("halt1", 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk("halt_empty", {31'd0, op_valid}, 32'd0); chk_ce("halt_idle", 1'b0, 8'h00);
    end
    nxt(); halt = 1'b0; #1; chk_ce("unhalt0", 1'b0, 8'h00);   // N38
    nxt(); #1; chk_ce("unhalt1", 1'b1, 8'h04);
    nxt(); #1; chk("unhalt_fill", {31'd0, op_valid}, 32'd0);
    nxt(); #1; chk_op("resume_04", 8'h04);
    nxt(); #1; chk_op("resume_05", 8'h05);   // N42
    // Jump requested while halted, honoured once released
    nxt(); halt = 1'b1; #1; chk_op("h2_q", 8'h06);
    nxt(); jmp_valid = 1'b1; jmp_addr = 8'h40; #1; chk_op("h2_last", 8'h07);
    nxt(); jmp_valid = 1'b0; #1;
    chk("h2_flush", {31'd0, op_valid}, 32'd0); chk_ce("h2_idle", 1'b0, 8'h00);
    nxt(); halt = 1'b0; #1; chk_ce("h2_rel0", 1'b0, 8'h00);
    nxt(); #1; chk_ce("h2_rel1", 1'b1, 8'h40);
    nxt(); #1; chk("h2_fill", {31'd0, op_valid}, 32'd0);
    nxt(); #1; chk_op("h2_op40", 8'h40);
    nxt(); #1; chk_op("h2_op41", 8'h41);

    // Test 6: reset mid-stream
    nxt(); reset_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_ce", {31'd0, ram_ce}, 32'd0);
    chk("mid_rst_ad", {24'd0, ram_ad}, 32'h00);
    chk("mid_rst_data", {24'd0, op_data}, 32'h00);
`ifdef OP_FETCH_STALLCNT_EN
    chk("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    nxt(); nxt(); reset_n = 1'b1; #1;
    chk("rerun_boot", {31'd0, ram_ce}, 32'd0);
    nxt(); #1; chk_ce("rerun_n1", 1'b1, 8'h00);
    nxt(); #1; chk("rerun_fill", {31'd0, op_valid}, 32'd0);
    nxt(); #1; chk_op("rerun_op0", 8'h00);
    nxt(); #1; chk_op("rerun_op1", 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
